reg_display_scanner: RTL and testbench

- Parametrised register-inspection display for the 32-bit CPU board.
- Replaces the fixed "one register on three static 7-seg digits" arrangement.
- Any of NUM_REGS CPU registers can be selected with two debounced push-buttons.
- The selected register is shown as hex on NUM_DIGITS time-multiplexed 7-segment digits, with tear-free per-frame snapshots, all in the single system clock domain (tick enable, no derived clock).

---
 rtl/display_pkg.sv | 28 ++
 rtl/reg_display_scanner_if.sv | 32 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/reg_display_scanner.sv | 104 ++++++++++
 tb/tb_reg_display_scanner.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_pkg
// Brief  : 7-segment encodings and small helpers shared by the scanner.
// Rev    : 1.0
// ============================================================================
package display_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Segment order is {g,f,e,d,c,b,a}; lower-case b and d avoid clashing with 8 and 0.
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_display_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : reg_display_scanner_if
// Brief  : Register bus, buttons and display outputs of the register scanner.
// Rev    : 1.0
// ============================================================================
interface reg_display_scanner_if #(
    parameter int NUM_REGS   = 26,
    parameter int NUM_DIGITS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [NUM_REGS*32-1:0] reg_bus;
    logic                   btn_next;
    logic                   btn_prev;
    logic [6:0]             seg;
    logic [NUM_DIGITS-1:0]  dig_en;
    logic [SEL_W-1:0]       sel_idx;
    logic                   frame_strobe;

    modport master (
        output reg_bus, btn_next, btn_prev,
        input  seg, dig_en, sel_idx, frame_strobe
    );

    modport slave (
        input  reg_bus, btn_next, btn_prev,
        output seg, dig_en, sel_idx, frame_strobe
    );

endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Synchronises a raw button, debounces it on scan ticks, pulses on press.
// Rev    : 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_tick,
    input  wire logic i_btn,
    output logic      o_press
);
    localparam int CNT_W = $clog2(DEB_TICKS + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_tick) begin
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_W'(DEB_TICKS - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= r_level;
        end
    end

    assign o_press = r_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/reg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module : reg_display_scanner
// Brief  : Button-selected CPU register shown as hex on multiplexed 7-seg digits.
// Rev    : 1.0
// ============================================================================
module reg_display_scanner
    import display_pkg::*;
#(
    parameter int NUM_REGS   = 26,
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 500,
    parameter int DEB_TICKS  = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    reg_display_scanner_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int D_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int T_W   = $clog2(DIV);

    logic [T_W-1:0]   r_tick_cnt;
    logic             w_tick;
    logic [D_W-1:0]   r_digit;
    logic [31:0]      r_snap;
    logic             r_strobe;
    logic [SEL_W-1:0] r_sel;
    logic             w_press_next;
    logic             w_press_prev;
    logic [4:0]       w_nib_lsb;
    logic [31:0]      w_regs [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign w_regs[k] = bus.reg_bus[32*k +: 32];
    end

    assign w_tick = (r_tick_cnt == T_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (w_tick),
        .i_btn   (bus.btn_next),
        .o_press (w_press_next)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (w_tick),
        .i_btn   (bus.btn_prev),
        .o_press (w_press_prev)
    );

    // Simultaneous presses cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (w_press_next && !w_press_prev) begin
            r_sel <= (r_sel == SEL_W'(NUM_REGS - 1)) ? '0 : r_sel + 1'b1;
        end else if (w_press_prev && !w_press_next) begin
            r_sel <= (r_sel == '0) ? SEL_W'(NUM_REGS - 1) : r_sel - 1'b1;
        end
    end

    // The snapshot is only reloaded as the scan returns to digit 0, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit  <= '0;
            r_snap   <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_tick) begin
                if (r_digit == D_W'(NUM_DIGITS - 1)) begin
                    r_digit  <= '0;
                    r_snap   <= w_regs[r_sel];
                    r_strobe <= 1'b1;
                end else begin
                    r_digit <= r_digit + 1'b1;
                end
            end
        end
    end

    assign w_nib_lsb        = 5'(r_digit) << 2;
    assign bus.seg          = hex_to_seg(r_snap[w_nib_lsb +: 4]);
    assign bus.dig_en       = NUM_DIGITS'(onehot(3'(r_digit)));
    assign bus.sel_idx      = r_sel;
    assign bus.frame_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_reg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_display_scanner
// Brief  : Self-checking bench for the register display scanner.
// Rev    : 1.0
// ============================================================================
module tb_reg_display_scanner;
    localparam int NUM_REGS   = 26;
    localparam int NUM_DIGITS = 4;
    localparam int DIV        = 4;
    localparam int DEB_TICKS  = 4;
    localparam int FRAME      = NUM_DIGITS * DIV;
    localparam int SETTLE     = DIV * (DEB_TICKS + 3);

    typedef struct {
        logic [31:0] val;
        logic [27:0] segs;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] regs [NUM_REGS];
    logic [27:0] exp_q [$];
    vec_t        tbl [4];
    int          n_vec = 0;
    int          n_err = 0;

    reg_display_scanner_if #(.NUM_REGS(NUM_REGS), .NUM_DIGITS(NUM_DIGITS)) bus ();

    reg_display_scanner #(
        .NUM_REGS   (NUM_REGS),
        .NUM_DIGITS (NUM_DIGITS),
        .DIV        (DIV),
        .DEB_TICKS  (DEB_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
        assign bus.reg_bus[32*g +: 32] = regs[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expect(input logic [31:0] v);
        exp_q.push_back({hex7(v[15:12]), hex7(v[11:8]), hex7(v[7:4]), hex7(v[3:0])});
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        for (int i = 1; i <= 4 * FRAME; i++) begin
            @(negedge clk);
            if (bus.frame_strobe) begin
                n = i;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL strobe_timeout: got no frame_strobe in %0d clk, required one", 4 * FRAME);
    endtask

    // Starts in the digit-0 slot of a fresh frame; optionally rewrites reg0 mid-frame.
    task automatic check_digits(input string name, input int change_at, input logic [31:0] new_val);
        logic [27:0] e;
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == change_at) regs[0] = new_val;
            chk($sformatf("%s_dig_en%0d", name, k), 32'(bus.dig_en), 32'(4'b0001 << k));
            chk($sformatf("%s_seg%0d", name, k), 32'(bus.seg), 32'(7'(e >> (7 * k))));
            if (k < NUM_DIGITS - 1) repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name);
        int n;
        wait_strobe(n);
        check_digits(name, -1, 32'h0);
    endtask

    task automatic press(input bit nxt);
        if (nxt) bus.btn_next = 1'b1; else bus.btn_prev = 1'b1;
        repeat (SETTLE) @(negedge clk);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        repeat (SETTLE) @(negedge clk);
    endtask

    initial begin
        int          first;
        int          n;
        int          changes;
        logic        pre_ok;
        logic [4:0]  last_sel;

        tbl[0] = '{32'h0000ABCD, {7'h77, 7'h7C, 7'h39, 7'h5E}};
        tbl[1] = '{32'hDEAD5678, {7'h6D, 7'h7D, 7'h07, 7'h7F}};
        tbl[2] = '{32'h12349E0F, {7'h6F, 7'h79, 7'h3F, 7'h71}};
        tbl[3] = '{32'hFFFF0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};

        rst_n        = 1'b0;
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_dig_en", 32'(bus.dig_en), 32'h1);
        chk("rst_seg", 32'(bus.seg), 32'h3F);
        chk("rst_sel", 32'(bus.sel_idx), 32'h0);
        chk("rst_strobe", 32'(bus.frame_strobe), 32'h0);

        // First frame after reset release
        regs[0] = 32'h00001234;
        rst_n   = 1'b1;
        first   = 0;
        pre_ok  = 1'b1;
        for (int i = 1; i <= 4 * FRAME && first == 0; i++) begin
            @(negedge clk);
            if (bus.frame_strobe) first = i;
            else if (bus.seg !== 7'h3F) pre_ok = 1'b0;
        end
        chk("first_strobe_clk", 32'(first), 32'(FRAME));
        chk("pre_frame_seg_3f", 32'(pre_ok), 32'h1);
        exp_q.push_back({7'h06, 7'h5B, 7'h4F, 7'h66});
        check_digits("t1", -1, 32'h0);

        for (int i = 0; i < 4; i++) begin
            regs[0] = tbl[i].val;
            exp_q.push_back(tbl[i].segs);
            check_frame($sformatf("tbl%0d", i));
        end
        regs[0] = 32'h00001234;

        // Long hold: exactly one increment
        changes  = 0;
        last_sel = bus.sel_idx;
        bus.btn_next = 1'b1;
        for (int i = 0; i < 18 * DIV; i++) begin
            if (i == 10 * DIV) bus.btn_next = 1'b0;
            @(negedge clk);
            if (bus.sel_idx !== last_sel) changes++;
            last_sel = bus.sel_idx;
        end
        chk("t2_hold_changes", 32'(changes), 32'h1);
        chk("t2_hold_sel", 32'(bus.sel_idx), 32'h1);

        bus.btn_prev = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        bus.btn_prev = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("t2_glitch_sel", 32'(bus.sel_idx), 32'h1);

        // Wrap-around both ways
        regs[25] = 32'hC0FF_EE25;
        press(1'b0);
        chk("t3_prev_to0", 32'(bus.sel_idx), 32'h0);
        press(1'b0);
        chk("t3_prev_wrap", 32'(bus.sel_idx), 32'd25);
        push_expect(regs[25]);
        check_frame("t3_r25");
        press(1'b1);
        chk("t3_next_wrap", 32'(bus.sel_idx), 32'h0);
        push_expect(32'h00001234);
        check_frame("t3_r0");

        // Simultaneous presses cancel; frame cadence undisturbed
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        wait_strobe(n);
        wait_strobe(n);
        chk("t4_frame_period", 32'(n), 32'(FRAME));
        repeat (6 * DIV) @(negedge clk);
        chk("t4_both_held_sel", 32'(bus.sel_idx), 32'h0);
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("t4_both_released_sel", 32'(bus.sel_idx), 32'h0);
        push_expect(32'h00001234);
        check_frame("t4");

        // Tearing: reg0 rewritten while digit 2 is lit
        push_expect(32'h00001234);
        wait_strobe(n);
        check_digits("t5_tear", 2, 32'h0000ABCD);
        exp_q.push_back({7'h77, 7'h7C, 7'h39, 7'h5E});
        check_frame("t5_next");

        // Mid-frame reset with a held button
        for (int i = 0; i < 7; i++) press(1'b1);
        chk("t6_sel7", 32'(bus.sel_idx), 32'h7);
        wait_strobe(n);
        bus.btn_next = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_sel7_before_rst", 32'(bus.sel_idx), 32'h7);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_dig_en", 32'(bus.dig_en), 32'h1);
        chk("t6_rst_seg", 32'(bus.seg), 32'h3F);
        chk("t6_rst_sel", 32'(bus.sel_idx), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (DEB_TICKS * DIV) @(negedge clk);
        chk("t6_sel_before_press", 32'(bus.sel_idx), 32'h0);
        @(negedge clk);
        chk("t6_sel_after_press", 32'(bus.sel_idx), 32'h1);
        repeat (10 * DIV) @(negedge clk);
        chk("t6_held_single_press", 32'(bus.sel_idx), 32'h1);
        bus.btn_next = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("t6_released_sel", 32'(bus.sel_idx), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
